// File: rtl/ov7670_capture_writer.sv
// OV7670 capture write side: RGB565 byte pairs -> RGB332 frame-buffer writes, clipped to the stored window.
// Optional colour-bar source for the written pixels when CAPTURE_TEST_PATTERN_EN is defined (adds TEST_MODE).
module ov7670_capture_writer #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_WIDTH    = 15
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  VSYNC,
    input  logic                  HREF,
    input  logic [7:0]            CAM_DATA,
`ifdef CAPTURE_TEST_PATTERN_EN
    input  logic                  TEST_MODE,
`endif
    output logic [7:0]            PIXEL_DATA,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic                  W_EN,
    output logic                  FRAME_DONE
);

    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 1);

    localparam logic [XW-1:0] X_LIMIT = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0] Y_LIMIT = YW'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {
        WAIT_FRAME  = 2'd0,
        FIRST_BYTE  = 2'd1,
        SECOND_BYTE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [7:0]              hi_q, hi_d;
    logic                    vsync_dly_q, href_dly_q;
    logic [7:0]              pixel_q, pixel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic                    done_q, done_d;

    logic                    vsync_fall, vsync_rise, href_fall;
    logic                    in_window;
    logic [7:0]              camera_pixel;
    logic [7:0]              write_pixel;
    logic [31:0]             addr_full;

    assign vsync_fall = vsync_dly_q & ~VSYNC;
    assign vsync_rise = ~vsync_dly_q & VSYNC;
    assign href_fall  = href_dly_q & ~HREF;

    // Top bits of each RGB565 field: R = hi[7:5], G = hi[2:0], B = lo[4:3].
    assign camera_pixel = {hi_q[7:5], hi_q[2:0], CAM_DATA[4:3]};
    assign in_window    = (x_q < X_LIMIT) && (y_q < Y_LIMIT);
    assign addr_full    = 32'(y_q) * 32'(SCREEN_WIDTH) + 32'(x_q);

`ifdef CAPTURE_TEST_PATTERN_EN
    localparam logic [XW-1:0] BAR_GREEN_X = XW'(SCREEN_WIDTH / 3);
    localparam logic [XW-1:0] BAR_BLUE_X  = XW'((2 * SCREEN_WIDTH) / 3);

    always_comb begin
        write_pixel = camera_pixel;
        if (TEST_MODE) begin
            if (x_q < BAR_GREEN_X) begin
                write_pixel = 8'b111_000_00;
            end else if (x_q < BAR_BLUE_X) begin
                write_pixel = 8'b000_111_00;
            end else begin
                write_pixel = 8'b000_000_11;
            end
        end
    end
`else
    assign write_pixel = camera_pixel;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        pixel_d = pixel_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (vsync_fall) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = FIRST_BYTE;
                end
            end
            default: begin
                // Frame end wins over line end and byte capture in the same cycle.
                if (vsync_rise) begin
                    done_d  = 1'b1;
                    state_d = WAIT_FRAME;
                end else if (href_fall) begin
                    x_d     = '0;
                    if (y_q < Y_LIMIT) begin
                        y_d = y_q + 1'b1;
                    end
                    state_d = FIRST_BYTE;
                end else if (HREF) begin
                    if (state_q == FIRST_BYTE) begin
                        hi_d    = CAM_DATA;
                        state_d = SECOND_BYTE;
                    end else begin
                        state_d = FIRST_BYTE;
                        if (in_window) begin
                            wen_d   = 1'b1;
                            pixel_d = write_pixel;
                            addr_d  = addr_full[ADDR_WIDTH-1:0];
                        end
                        if (x_q < X_LIMIT) begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= WAIT_FRAME;
            x_q         <= '0;
            y_q         <= '0;
            hi_q        <= '0;
            vsync_dly_q <= 1'b1;
            href_dly_q  <= 1'b0;
            pixel_q     <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hi_q        <= hi_d;
            vsync_dly_q <= VSYNC;
            href_dly_q  <= HREF;
            pixel_q     <= pixel_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
        end
    end

    assign PIXEL_DATA = pixel_q;
    assign W_ADDR     = addr_q;
    assign W_EN       = wen_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// Bench for ov7670_capture_writer: directed frame scenarios plus random lines against a pixel-level model.
module tb_ov7670_capture_writer;

  localparam int W  = 176;
  localparam int H  = 144;
  localparam int AW = 15;
  localparam int QW = AW + 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic          test_mode = 1'b0;
  logic [7:0]    pixel_data;
  logic [AW-1:0] w_addr;
  logic          w_en;
  logic          frame_done;

  always #5 clk = ~clk;

  ov7670_capture_writer #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_WIDTH   (AW)
  ) dut (
    .CLOCK     (clk),
    .RESET     (reset),
    .VSYNC     (vsync),
    .HREF      (href),
    .CAM_DATA  (cam_data),
`ifdef CAPTURE_TEST_PATTERN_EN
    .TEST_MODE (test_mode),
`endif
    .PIXEL_DATA(pixel_data),
    .W_ADDR    (w_addr),
    .W_EN      (w_en),
    .FRAME_DONE(frame_done)
  );

  int total = 0;
  int bad   = 0;

  logic [QW-1:0] exp_q[$];
  logic [7:0]    obs_mem[0:(1<<AW)-1];

  // Pixel-level model of the capture: frame/line/byte bookkeeping only.
  bit          m_in_frame;
  bit          m_have_hi;
  logic [7:0]  m_hi;
  int          m_x;
  int          m_y;
  bit          m_prev_vs;
  bit          m_prev_hr;
  bit          e_wen;
  bit          e_done;
  logic [AW-1:0] e_addr;
  logic [7:0]  e_data;

  int          wcount;
  int          done_cnt;
  logic [AW-1:0] last_addr;
  logic [7:0]  last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] expected_pixel(input logic [7:0] hi, input logic [7:0] lo, input int x);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    if (test_mode) begin
      if (x < W / 3)          return 8'hE0;
      else if (x < 2 * W / 3) return 8'h1C;
      else                    return 8'h03;
    end
    return {r5[4:2], g6[5:3], b5[4:3]};
  endfunction

  task automatic model_step(input bit rst, input bit vs, input bit hr, input logic [7:0] d);
    int a;
    e_wen  = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_in_frame = 1'b0;
      m_have_hi  = 1'b0;
      m_hi       = 8'h00;
      m_x        = 0;
      m_y        = 0;
      m_prev_vs  = 1'b1;
      m_prev_hr  = 1'b0;
      e_addr     = '0;
      e_data     = 8'h00;
      return;
    end
    if (!m_in_frame) begin
      if (m_prev_vs && !vs) begin
        m_in_frame = 1'b1;
        m_have_hi  = 1'b0;
        m_x        = 0;
        m_y        = 0;
      end
    end else if (!m_prev_vs && vs) begin
      e_done     = 1'b1;
      m_in_frame = 1'b0;
    end else if (m_prev_hr && !hr) begin
      m_x       = 0;
      m_y       = (m_y < H) ? m_y + 1 : H;
      m_have_hi = 1'b0;
    end else if (hr) begin
      if (!m_have_hi) begin
        m_hi      = d;
        m_have_hi = 1'b1;
      end else begin
        m_have_hi = 1'b0;
        if (m_x < W && m_y < H) begin
          a      = m_y * W + m_x;
          e_wen  = 1'b1;
          e_addr = AW'(a);
          e_data = expected_pixel(m_hi, d, m_x);
        end
        m_x = (m_x < W) ? m_x + 1 : W;
      end
    end
    m_prev_vs = vs;
    m_prev_hr = hr;
  endtask

  task automatic tick(input bit rst, input bit vs, input bit hr, input logic [7:0] d);
    logic [QW-1:0] w;
    @(negedge clk);
    reset    = rst;
    vsync    = vs;
    href     = hr;
    cam_data = d;
    @(posedge clk);
    model_step(rst, vs, hr, d);
    if (e_wen) exp_q.push_back({e_addr, e_data});
    #1;
    chk("w_en", {31'b0, w_en}, {31'b0, e_wen});
    chk("frame_done", {31'b0, frame_done}, {31'b0, e_done});
    if (frame_done) done_cnt++;
    if (w_en) begin
      wcount++;
      last_addr = w_addr;
      last_data = pixel_data;
      obs_mem[w_addr] = pixel_data;
      if (exp_q.size() == 0) begin
        chk("write_expected", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("write_word", 32'({w_addr, pixel_data}), 32'(w));
      end
    end
  endtask

  task automatic end_frame();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic begin_frame();
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // npix full pixels, optional trailing odd byte, then a short HREF-low gap.
  task automatic send_line(input int npix, input bit odd, input bit zero_data);
    logic [7:0] b;
    for (int i = 0; i < 2 * npix + (odd ? 1 : 0); i++) begin
      b = zero_data ? 8'h00 : 8'($urandom_range(0, 255));
      tick(1'b0, 1'b0, 1'b1, b);
    end
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    wcount   = 0;
    done_cnt = 0;

    // Reset state
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 8'h00);
    chk("reset_w_addr", 32'(w_addr), 32'd0);
    chk("reset_pixel", 32'(pixel_data), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);

    // Single pixel at the origin
    begin_frame();
    wcount = 0;
    tick(1'b0, 1'b0, 1'b1, 8'hE3);
    tick(1'b0, 1'b0, 1'b1, 8'h18);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1_count", 32'(wcount), 32'd1);
    chk("t1_addr", 32'(last_addr), 32'd0);
    chk("t1_data", 32'(last_data), 32'(expected_pixel(8'hE3, 8'h18, 0)));
    end_frame();

    // Over-wide line then a short second line
    begin_frame();
    wcount = 0;
    send_line(180, 1'b0, 1'b0);
    chk("t2_line0_count", 32'(wcount), 32'd176);
    chk("t2_line0_last", 32'(last_addr), 32'd175);
    send_line(2, 1'b0, 1'b0);
    chk("t2_count", 32'(wcount), 32'd178);
    chk("t2_last", 32'(last_addr), 32'd177);
    end_frame();

    // Full frame with extra lines below the window
    begin_frame();
    wcount = 0;
    for (int l = 0; l < H + 4; l++) send_line(W, 1'b0, 1'b0);
    chk("t3_count", 32'(wcount), 32'(W * H));
    chk("t3_last", 32'(last_addr), 32'(W * H - 1));
    done_cnt = 0;
    end_frame();
    chk("t3_done_pulses", 32'(done_cnt), 32'd1);

    // Odd byte at end of line is dropped
    begin_frame();
    wcount = 0;
    send_line(1, 1'b1, 1'b0);
    chk("t4_line0_count", 32'(wcount), 32'd1);
    send_line(1, 1'b0, 1'b0);
    chk("t4_count", 32'(wcount), 32'd2);
    chk("t4_addr", 32'(last_addr), 32'd176);
    end_frame();

    // Reset in the middle of a line
    begin_frame();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    wcount   = 0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
      chk("t5_rst_w_addr", 32'(w_addr), 32'd0);
    end
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_no_write", 32'(wcount), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    begin_frame();
    send_line(4, 1'b0, 1'b0);
    chk("t5_restart_count", 32'(wcount), 32'd4);
    chk("t5_restart_last", 32'(last_addr), 32'd3);
    end_frame();

    // Random frames, including VSYNC rising during a byte
    for (int f = 0; f < 4; f++) begin
      begin_frame();
      for (int l = 0; l < int'($urandom_range(1, 6)); l++)
        send_line(int'($urandom_range(0, 190)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        tick(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      end
      end_frame();
    end

`ifdef CAPTURE_TEST_PATTERN_EN
    // Colour bars replace camera data
    test_mode = 1'b1;
    begin_frame();
    send_line(W, 1'b0, 1'b1);
    chk("t6_bar_x0", 32'(obs_mem[0]), 32'hE0);
    chk("t6_bar_x60", 32'(obs_mem[60]), 32'h1C);
    chk("t6_bar_x120", 32'(obs_mem[120]), 32'h03);
    end_frame();
    test_mode = 1'b0;
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
